// File: rtl/colparity_theta_engine_pkg.sv
// Shared types and helpers for the column-parity theta engine.
package colparity_theta_engine_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    PASS2 = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic MODE_THETA  = 1'b0;
  localparam logic MODE_PARITY = 1'b1;

  // Position of lane bit A[x][y] inside a slice word.
  function automatic int bit_idx(input int dim, input int x, input int y);
    return dim * y + x;
  endfunction

endpackage

// File: rtl/colparity_slice.sv
// Combinational column parity and theta step for one DIM x DIM slice.
module colparity_slice
  import colparity_theta_engine_pkg::*;
#(
  parameter int  DIM = 5,
  localparam int W   = DIM * DIM
) (
  input  logic [W-1:0]   slice,
  input  logic [DIM-1:0] prev_par,
  output logic [DIM-1:0] par,
  output logic [W-1:0]   theta
);

  function automatic logic [DIM-1:0] col_parity(input logic [W-1:0] s);
    logic [DIM-1:0] p;
    p = {DIM{1'b0}};
    for (int x = 0; x < DIM; x++) begin
      for (int y = 0; y < DIM; y++) begin
        p[x] = p[x] ^ s[bit_idx(DIM, x, y)];
      end
    end
    return p;
  endfunction

  // Column parity of the current slice.
  always_comb begin
    par = col_parity(slice);
  end

  // Left neighbour from this slice, right neighbour from the previous slice.
  always_comb begin
    theta = {W{1'b0}};
    for (int x = 0; x < DIM; x++) begin
      for (int y = 0; y < DIM; y++) begin
        theta[bit_idx(DIM, x, y)] = slice[bit_idx(DIM, x, y)]
                                  ^ par[(x + DIM - 1) % DIM]
                                  ^ prev_par[(x + 1) % DIM];
      end
    end
  end

endmodule

// File: rtl/colparity_theta_engine.sv
// Two-pass engine: pass 1 collects column parities, pass 2 writes theta(state);
// parity mode writes the parity plane during pass 1 and stops there.
module colparity_theta_engine
  import colparity_theta_engine_pkg::*;
#(
  parameter int  DIM    = 5,
  parameter int  DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int W      = DIM * DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] cnt_value,
  input  logic [W-1:0]      line_in,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [W-1:0]      write_value,
  output logic              busy,
  output logic              donee
);

  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  state_t            state_r, state_s;
  logic              mode_r, mode_s;
  logic [ADDR_W-1:0] cnt_s, waddr_s, prev_addr_s;
  logic              we_s, done_s, busy_s, par_we_s;
  logic [W-1:0]      wval_s, theta_s;
  logic [DIM-1:0]    par_s, prev_par_s;
  logic [DIM-1:0]    par_mem_r [DEPTH];

  // Slice z-1 wraps to DEPTH-1 at z=0; its parity was stored during pass 1.
  assign prev_addr_s = (cnt_value == ZERO_A) ? LAST_A : cnt_value - ONE_A;
  assign prev_par_s  = par_mem_r[prev_addr_s];

  colparity_slice #(.DIM(DIM)) u_slice (
    .slice    (line_in),
    .prev_par (prev_par_s),
    .par      (par_s),
    .theta    (theta_s)
  );

  // Next-state, counter and write-port decode.
  always_comb begin
    state_s  = state_r;
    mode_s   = mode_r;
    cnt_s    = cnt_value;
    we_s     = 1'b0;
    waddr_s  = write_addr;
    wval_s   = write_value;
    done_s   = 1'b0;
    par_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = ZERO_A;
        if (start) begin
          state_s = PASS1;
          mode_s  = mode;
        end else begin
          state_s = IDLE;
        end
      end
      PASS1: begin
        par_we_s = 1'b1;
        if (mode_r == MODE_PARITY) begin
          we_s    = 1'b1;
          waddr_s = cnt_value;
          wval_s  = {{(W - DIM){1'b0}}, par_s};
        end else begin
          we_s = 1'b0;
        end
        if (cnt_value == LAST_A) begin
          cnt_s   = ZERO_A;
          state_s = (mode_r == MODE_PARITY) ? FLUSH : PASS2;
        end else begin
          cnt_s = cnt_value + ONE_A;
        end
      end
      PASS2: begin
        we_s    = 1'b1;
        waddr_s = cnt_value;
        wval_s  = theta_s;
        if (cnt_value == LAST_A) begin
          cnt_s   = ZERO_A;
          state_s = FLUSH;
        end else begin
          cnt_s = cnt_value + ONE_A;
        end
      end
      FLUSH: begin
        cnt_s   = ZERO_A;
        done_s  = 1'b1;
        state_s = DONE;
      end
      DONE: begin
        cnt_s = ZERO_A;
        if (start) begin
          done_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        cnt_s   = ZERO_A;
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == PASS1) || (state_s == PASS2);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      mode_r       <= MODE_THETA;
      cnt_value    <= ZERO_A;
      write_enable <= 1'b0;
      write_addr   <= ZERO_A;
      write_value  <= {W{1'b0}};
      busy         <= 1'b0;
      donee        <= 1'b0;
    end else begin
      state_r      <= state_s;
      mode_r       <= mode_s;
      cnt_value    <= cnt_s;
      write_enable <= we_s;
      write_addr   <= waddr_s;
      write_value  <= wval_s;
      busy         <= busy_s;
      donee        <= done_s;
    end
  end

  // Parity plane store; contents survive reset and are rewritten every pass 1.
  always_ff @(posedge clk) begin
    if (par_we_s) begin
      par_mem_r[cnt_value] <= par_s;
    end
  end

endmodule

// File: tb/tb_colparity_theta_engine.sv
// Scoreboard bench for colparity_theta_engine (5x5x64 and 3x3x4 instances).
module tb_colparity_theta_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode, start3, mode3;
  logic [5:0]  cnt_value, write_addr;
  logic [24:0] line_in, write_value;
  logic        write_enable, busy, donee;
  logic [1:0]  cnt3, waddr3;
  logic [8:0]  line3, wval3;
  logic        we3, busy3, done3;

  logic [24:0] mem [64];
  logic [24:0] exp_arr [64];
  logic [8:0]  mem3 [4];
  logic [8:0]  got3 [4];
  int          n3 = 0;

  logic [24:0] exp_w_q [$];
  int          exp_a_q [$];
  int          exp_e_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic ignore_wr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign line_in = mem[cnt_value];
  assign line3   = mem3[cnt3];

  colparity_theta_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cnt_value(cnt_value),
    .line_in(line_in), .write_enable(write_enable), .write_addr(write_addr),
    .write_value(write_value), .busy(busy), .donee(donee)
  );

  colparity_theta_engine #(.DIM(3), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3), .cnt_value(cnt3),
    .line_in(line3), .write_enable(we3), .write_addr(waddr3),
    .write_value(wval3), .busy(busy3), .donee(done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write-port scoreboard for the 5x5x64 instance.
  always @(negedge clk) begin
    if (write_enable && !ignore_wr) begin
      total++;
      assert (exp_w_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed_addr=%0d expected=no_write", write_addr);
      end
      if (exp_w_q.size() != 0) begin
        chk("wr_addr", 32'(write_addr), 32'(exp_a_q.pop_front()));
        chk("wr_data", 32'(write_value), 32'(exp_w_q.pop_front()));
        chk("wr_edge", 32'(cyc - start_cyc), 32'(exp_e_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (we3) begin
      got3[waddr3] = wval3;
      n3++;
    end
  end

  function automatic void build_exp(input logic m);
    logic [4:0] c [64];
    for (int z = 0; z < 64; z++)
      for (int x = 0; x < 5; x++)
        c[z][x] = mem[z][x] ^ mem[z][5+x] ^ mem[z][10+x] ^ mem[z][15+x] ^ mem[z][20+x];
    for (int z = 0; z < 64; z++) begin
      if (m) exp_arr[z] = {20'd0, c[z]};
      else
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++)
            exp_arr[z][5*y+x] = mem[z][5*y+x] ^ c[z][(x+4)%5] ^ c[(z+63)%64][(x+1)%5];
    end
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 64; i++) begin
      mem[i] = 25'd0;
      exp_arr[i] = 25'd0;
    end
  endtask

  task automatic run5(input logic m);
    int k;
    for (int i = 0; i < 64; i++) begin
      exp_w_q.push_back(exp_arr[i]);
      exp_a_q.push_back(i);
      exp_e_q.push_back(m ? i + 1 : 65 + i);
    end
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    mode = ~m;
    chk("busy_run", 32'(busy), 32'd1);
    k = 0;
    while (!donee && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(donee), 32'd1);
    chk("done_edge", 32'(cyc - start_cyc), m ? 32'd65 : 32'd129);
    chk("queue_drained", 32'(exp_w_q.size()), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("done_held", 32'(donee), 32'd1);
    chk("cnt_done", 32'(cnt_value), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(donee), 32'd0);
    exp_w_q.delete();
    exp_a_q.delete();
    exp_e_q.delete();
  endtask

  initial begin
    int k;
    rst = 1'b0; start = 1'b0; mode = 1'b0; start3 = 1'b0; mode3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem3[i] = 9'd0;
      got3[i] = 9'd0;
    end
    clear_all();
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_cnt", 32'(cnt_value), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    chk("rst_val", 32'(write_value), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(donee), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    clear_all();
    run5(1'b0);

    clear_all();
    mem[0] = 25'h0000001;
    exp_arr[0] = 25'h0210843;
    exp_arr[1] = 25'h1084210;
    run5(1'b0);

    clear_all();
    mem[63] = 25'h0000001;
    exp_arr[63] = 25'h0210843;
    exp_arr[0]  = 25'h1084210;
    run5(1'b0);

    clear_all();
    mem[0] = 25'h1FFFFFF;
    mem[1] = 25'h000001F;
    mem[2] = 25'h0000021;
    build_exp(1'b1);
    run5(1'b1);

    for (int i = 0; i < 64; i++) mem[i] = 25'($urandom());
    build_exp(1'b0);
    run5(1'b0);

    // Reset in the middle of pass 2, then a clean rerun.
    ignore_wr = 1'b1;
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    repeat (70) @(posedge clk);
    #1;
    chk("pre_rst_we", 32'(write_enable), 32'd1);
    #1;
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("mid_rst_we", 32'(write_enable), 32'd0);
    chk("mid_rst_done", 32'(donee), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_value), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    ignore_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    run5(1'b0);

    // 3x3x4 instance: both x and z wraps.
    mem3[0] = 9'h001;
    n3 = 0;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    k = 0;
    while (!done3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("d3_done_edge", 32'(cyc - start_cyc), 32'd9);
    chk("d3_nwr", 32'(n3), 32'd4);
    chk("d3_w0", 32'(got3[0]), 32'h093);
    chk("d3_w1", 32'(got3[1]), 32'h124);
    chk("d3_w2", 32'(got3[2]), 32'h000);
    chk("d3_w3", 32'(got3[3]), 32'h000);
    start3 = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
